// File: rtl/sync_fifo_pkg.sv
// ============================================================================
// Module      : sync_fifo_pkg
// Description : Shared types and helpers for the programmable sync FIFO.
//               Parity storage controlled by SYNC_FIFO_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

`ifdef SYNC_FIFO_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    function automatic int fifo_depth(input int depth_len);
        return 1 << depth_len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_mem.sv
// ============================================================================
// Module      : sync_fifo_mem
// Description : Register file, one synchronous write port, one async read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_mem #(
    parameter int WIDTH     = 8,
    parameter int DEPTH_LEN = 4
) (
    input  logic                 i_clk,
    input  logic                 i_we,
    input  logic [DEPTH_LEN-1:0] i_waddr,
    input  logic [WIDTH-1:0]     i_wdata,
    input  logic [DEPTH_LEN-1:0] i_raddr,
    output logic [WIDTH-1:0]     o_rdata
);

    logic [WIDTH-1:0] r_mem [0:(1<<DEPTH_LEN)-1];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/sync_fifo_prog.sv
// ============================================================================
// Module      : sync_fifo_prog
// Description : Single-clock FIFO with FWFT/registered read, programmable
//               almost flags, fill count and sticky errors.
//               Optional parity: define SYNC_FIFO_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_prog
    import sync_fifo_pkg::*;
#(
    parameter int         WIDTH         = 8,
    parameter int         DEPTH_LEN     = 4,
    parameter int         AFULL_THRESH  = 14,
    parameter int         AEMPTY_THRESH = 2,
    parameter fifo_mode_e FWFT          = FIFO_FWFT
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [WIDTH-1:0]     i_data,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic                 i_clr_err,
    output logic [WIDTH-1:0]     o_data,
    output logic                 o_valid,
    output logic                 o_full,
    output logic                 o_empty,
    output logic                 o_almost_full,
    output logic                 o_almost_empty,
    output logic [DEPTH_LEN:0]   o_fill,
    output logic                 o_overflow,
    output logic                 o_underflow
`ifdef SYNC_FIFO_PARITY_EN
    ,
    output logic                 o_parity_err
`endif
);

    localparam int c_DEPTH = fifo_depth(DEPTH_LEN);
    localparam int c_PW    = DEPTH_LEN + 1;
    localparam int c_MW    = WIDTH + PARITY_BITS;

    localparam logic [c_PW-1:0] c_FULL_VAL = c_PW'(c_DEPTH);
    localparam logic [c_PW-1:0] c_AFULL    = c_PW'(AFULL_THRESH);
    localparam logic [c_PW-1:0] c_AEMPTY   = c_PW'(AEMPTY_THRESH);

    if (AFULL_THRESH < 1 || AFULL_THRESH > c_DEPTH) begin : g_bad_afull
        $error("sync_fifo_prog: AFULL_THRESH out of range 1..depth");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > c_DEPTH - 1) begin : g_bad_aempty
        $error("sync_fifo_prog: AEMPTY_THRESH out of range 0..depth-1");
    end

    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_PW-1:0] w_fill;
    logic            w_wr_req;
    logic            w_rd_req;
    logic [c_MW-1:0] w_wr_word;
    logic [c_MW-1:0] w_rd_word;
    logic            r_overflow;
    logic            r_underflow;

    // Flags decode pointers only, so they never combinationally depend on requests.
    assign w_fill         = r_wr_ptr - r_rd_ptr;
    assign o_fill         = w_fill;
    assign o_full         = (w_fill == c_FULL_VAL);
    assign o_empty        = (w_fill == '0);
    assign o_almost_full  = (w_fill >= c_AFULL);
    assign o_almost_empty = (w_fill <= c_AEMPTY);

    assign w_wr_req = wr_en & ~o_full;
    assign w_rd_req = rd_en & ~o_empty;

`ifdef SYNC_FIFO_PARITY_EN
    assign w_wr_word = {^i_data, i_data};
`else
    assign w_wr_word = i_data;
`endif

    sync_fifo_mem #(
        .WIDTH     (c_MW),
        .DEPTH_LEN (DEPTH_LEN)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_wr_req),
        .i_waddr (r_wr_ptr[DEPTH_LEN-1:0]),
        .i_wdata (w_wr_word),
        .i_raddr (r_rd_ptr[DEPTH_LEN-1:0]),
        .o_rdata (w_rd_word)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_req) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_req) r_rd_ptr <= r_rd_ptr + 1'b1;
            // A new error in the clearing cycle takes priority.
            if (wr_en && o_full)  r_overflow  <= 1'b1;
            else if (i_clr_err)   r_overflow  <= 1'b0;
            if (rd_en && o_empty) r_underflow <= 1'b1;
            else if (i_clr_err)   r_underflow <= 1'b0;
        end
    end

    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

    if (FWFT == FIFO_FWFT) begin : g_fwft
        assign o_data  = w_rd_word[WIDTH-1:0];
        assign o_valid = ~o_empty;
    end else begin : g_std
        logic [WIDTH-1:0] r_data;
        logic             r_valid;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_valid <= w_rd_req;
                if (w_rd_req) r_data <= w_rd_word[WIDTH-1:0];
            end
        end

        assign o_data  = r_data;
        assign o_valid = r_valid;
    end

`ifdef SYNC_FIFO_PARITY_EN
    logic r_parity_err;
    logic w_par_bad;

    // Even parity over data plus stored bit folds to zero for a clean word.
    assign w_par_bad = ^w_rd_word;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                  r_parity_err <= 1'b0;
        else if (w_rd_req && w_par_bad) r_parity_err <= 1'b1;
        else if (i_clr_err)            r_parity_err <= 1'b0;
    end

    if (FWFT == FIFO_FWFT) begin : g_perr_fwft
        assign o_parity_err = r_parity_err | (~o_empty & w_par_bad);
    end else begin : g_perr_std
        assign o_parity_err = r_parity_err;
    end
`endif

endmodule

`default_nettype wire
